// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target.
// Frame width, byte type, link state and default fill byte.
package spi_target_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_tgt_state_e;

  localparam byte_t FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchroniser for one asynchronous SPI input.
// Reset value is a parameter so idle-high lines do not glitch.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) s <= {STAGES{RST_VAL}};
    else     s <= {s[STAGES-2:0], d};
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target: oversampled on wb_clk, byte pulse rx,
// one-entry tx buffer with fill byte on underrun.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter byte_t FILL_BYTE   = FILL_DEFAULT
) (
  input  logic  wb_clk,
  input  logic  wb_rst,
  input  logic  spi_sck,
  input  logic  spi_copi,
  output logic  spi_cipo,
  input  logic  spi_cs,
  input  logic  spi_nrst,
  output byte_t rx_data,
  output logic  rx_valid,
  input  byte_t tx_data,
  input  logic  tx_valid,
  output logic  tx_ready,
  output logic  tx_underrun,
  output logic  cs_active
);

  logic nrst_s;
  logic link_rst;
  logic sck_s, cs_s, copi_s;
  logic sck_q, cs_q, copi_r;
  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  spi_tgt_state_e state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] rx_shift;
  byte_t             tx_shift;
  byte_t             buf_data;
  logic              buf_valid;
  logic              load_req;
  byte_t             next_byte;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nrst (
    .clk(wb_clk), .rst(wb_rst), .d(spi_nrst), .q(nrst_s)
  );

  assign link_rst = wb_rst | ~nrst_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(wb_clk), .rst(link_rst), .d(spi_sck), .q(sck_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(wb_clk), .rst(link_rst), .d(spi_cs), .q(cs_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(wb_clk), .rst(link_rst), .d(spi_copi), .q(copi_s)
  );

  // Edge strobes are registered; copi is delayed to stay aligned.
  always_ff @(posedge wb_clk) begin
    if (link_rst) begin
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      copi_r   <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_rise  <= 1'b0;
      cs_fall  <= 1'b0;
    end else begin
      sck_q    <= sck_s;
      cs_q     <= cs_s;
      copi_r   <= copi_s;
      sck_rise <= sck_s & ~sck_q;
      sck_fall <= ~sck_s & sck_q;
      cs_rise  <= cs_s & ~cs_q;
      cs_fall  <= ~cs_s & cs_q;
    end
  end

  assign load_req = ~link_rst & (
    (state == IDLE && cs_fall) ||
    (state == ACTIVE && !cs_rise && !cs_fall &&
     sck_fall && bit_cnt == 3'd0));

  assign next_byte = buf_valid ? buf_data : FILL_BYTE;
  assign tx_ready  = ~buf_valid;
  assign cs_active = (state == ACTIVE);

  // The buffer survives a link reset; only wb_rst empties it.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (load_req && buf_valid) begin
      buf_valid <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      buf_valid <= 1'b1;
      buf_data  <= tx_data;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (link_rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      spi_cipo    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= 3'd0;
            tx_shift    <= next_byte;
            spi_cipo    <= next_byte[BYTE_W-1];
            tx_underrun <= ~buf_valid;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            spi_cipo <= 1'b0;
          end else if (cs_fall) begin
            bit_cnt <= bit_cnt;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[BYTE_W-3:0], copi_r};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {rx_shift, copi_r};
              rx_valid <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= tx_shift << 1;
              spi_cipo <= tx_shift[BYTE_W-2];
            end else begin
              tx_shift    <= next_byte;
              spi_cipo    <= next_byte[BYTE_W-1];
              tx_underrun <= ~buf_valid;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
